// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE / ISSUE / RESP)
//   PORT_IF / PORT_D : requester IDs, also used as the last-grant encoding
//   mem_cmd_t   : command latched at handshake and replayed to the memory
// The command struct is sized for the default arbiter geometry
// (MEM_DWIDTH data bits, MEM_AWIDTH byte-address bits).
package mem_arb_pkg;

    localparam int MEM_DWIDTH = 32;
    localparam int MEM_AWIDTH = 16;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                      port;
        logic [MEM_AWIDTH-3:0]     widx;
        logic [MEM_DWIDTH/8-1:0]   wbe;
        logic [MEM_DWIDTH-1:0]     wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational two-way grant between fetch and data requesters.
//   if_valid, d_valid : request valids
//   last_grant        : port granted on the previous handshake
//   grant_if, grant_d : one-hot (or zero) grant
// Optional feature macro MEM_ARB_RR_EN: when defined, a tie goes to the port
// that was not granted last; otherwise data always beats fetch and
// last_grant is ignored.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_valid,
    input  logic d_valid,
    input  logic last_grant,
    output logic grant_if,
    output logic grant_d
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_valid && d_valid) begin
            if (last_grant == PORT_IF) begin
                grant_d = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
        end else begin
            grant_if = if_valid;
            grant_d  = d_valid;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign grant_d  = d_valid;
    assign grant_if = if_valid && !d_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous-read memory between the
// instruction-fetch port and the load/store port.
//   clk, rst              : clock, synchronous active-high reset
//   if_req_* / if_rsp_*   : fetch request (valid/ready/addr) and response pulse
//   d_req_*  / d_rsp_*    : data request (valid/ready/addr/wbe/wdata) and
//                           response pulse (load data, or 0 for a store ack)
//   mem_addr/mem_wbe/mem_dw : memory word index, byte enables, write data
//   mem_dr                : memory read data, one cycle after the address
// Optional feature macro MEM_ARB_RR_EN selects round-robin arbitration
// (default build: fixed priority, data over fetch).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; a handshake latches the command
// ISSUE | drive latched command to memory; a store commits this cycle
// RESP  | pulse rsp_valid on the granted port with mem_dr (or 0 for store)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH = MEM_DWIDTH,
    parameter int AWIDTH = MEM_AWIDTH
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [DWIDTH-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DWIDTH-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [DWIDTH-1:0]   d_req_addr,
    input  logic [DWIDTH/8-1:0] d_req_wbe,
    input  logic [DWIDTH-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [DWIDTH-1:0]   d_rsp_rdata,
    output logic [AWIDTH-3:0]   mem_addr,
    output logic [DWIDTH/8-1:0] mem_wbe,
    output logic [DWIDTH-1:0]   mem_dw,
    input  logic [DWIDTH-1:0]   mem_dr
);

    arb_state_t state_q;
    arb_state_t state_d;
    mem_cmd_t   cmd_q;

    logic grant_if;
    logic grant_d;
    logic hs_if;
    logic hs_d;
    logic last_grant;
    logic rsp_live;

    // Byte-offset bits and bits above the memory size carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_req_addr[DWIDTH-1:AWIDTH], if_req_addr[1:0],
                                d_req_addr[DWIDTH-1:AWIDTH],  d_req_addr[1:0]};

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT_IF;
        end else if (hs_d) begin
            last_grant_q <= PORT_D;
        end else if (hs_if) begin
            last_grant_q <= PORT_IF;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT_IF;
`endif

    arb_pick u_pick (
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
        .last_grant (last_grant),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    // ready is held low during reset so no handshake is taken on a reset edge.
    assign if_req_ready = !rst && (state_q == IDLE) && grant_if;
    assign d_req_ready  = !rst && (state_q == IDLE) && grant_d;
    assign hs_if        = if_req_valid && if_req_ready;
    assign hs_d         = d_req_valid && d_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hs_d) begin
                cmd_q <= '{port:  PORT_D,
                           widx:  d_req_addr[AWIDTH-1:2],
                           wbe:   d_req_wbe,
                           wdata: d_req_wdata};
            end else if (hs_if) begin
                cmd_q <= '{port:  PORT_IF,
                           widx:  if_req_addr[AWIDTH-1:2],
                           wbe:   '0,
                           wdata: '0};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rsp_live     = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = '0;
        mem_wbe      = '0;

        unique case (state_q)
            IDLE: begin
                if (hs_if || hs_d) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (!rst) begin
                    mem_wbe = cmd_q.wbe;
                end
            end
            RESP: begin
                state_d  = IDLE;
                // A response in flight during reset is dropped.
                rsp_live = !rst;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rsp_live) begin
            if (cmd_q.port == PORT_IF) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = mem_dr;
            end else begin
                d_rsp_valid = 1'b1;
                d_rsp_rdata = (cmd_q.wbe == '0) ? mem_dr : '0;
            end
        end
    end

    assign mem_addr = cmd_q.widx;
    assign mem_dw   = cmd_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int BW = DW / 8;
    localparam int NW = 1 << (AW - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [DW-1:0] if_req_addr  = '0;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid  = 1'b0;
    logic          d_req_ready;
    logic [DW-1:0] d_req_addr   = '0;
    logic [BW-1:0] d_req_wbe    = '0;
    logic [DW-1:0] d_req_wdata  = '0;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_rdata;
    logic [AW-3:0] mem_addr;
    logic [BW-1:0] mem_wbe;
    logic [DW-1:0] mem_dw;
    logic [DW-1:0] mem_dr = '0;

    mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_wbe    (d_req_wbe),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_wbe      (mem_wbe),
        .mem_dw       (mem_dw),
        .mem_dr       (mem_dr)
    );

    // Memory macro seen by the DUT, and the reference copy kept by the model.
    logic [DW-1:0] bmem [NW];
    logic [DW-1:0] rmem [NW];

    always @(posedge clk) begin
        for (int b = 0; b < BW; b++) begin
            if (mem_wbe[b]) bmem[mem_addr][8*b +: 8] <= mem_dw[8*b +: 8];
        end
        mem_dr <= bmem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          ncyc     = 0;
    bit          have_txn = 1'b0;
    int          t_hs     = 0;
    bit          tx_is_d  = 1'b0;
    logic [13:0] tx_idx   = '0;
    logic [3:0]  tx_wbe   = '0;
    logic [31:0] tx_wd    = '0;
    logic [13:0] lat_idx  = '0;
    bit          last_d   = 1'b0;   // 1: data port was granted last
    bit          dut_hs_if = 1'b0;
    bit          dut_hs_d  = 1'b0;
    int          if_rsp_cnt = 0;

    always @(negedge clk) begin
        bit          e_ifr, e_dr, e_ifv, e_dv, idle, win_if, win_d;
        logic [31:0] e_ifd, e_dd;
        logic [3:0]  e_wbe;
        e_ifr = 0; e_dr = 0; e_ifv = 0; e_dv = 0; win_if = 0; win_d = 0;
        e_ifd = '0; e_dd = '0; e_wbe = '0;

        dut_hs_if = if_req_valid && if_req_ready;
        dut_hs_d  = d_req_valid && d_req_ready;
        if (if_rsp_valid) if_rsp_cnt++;

        if (rst) begin
            check("rst_if_ready", 32'(if_req_ready), 32'(e_ifr));
            check("rst_d_ready",  32'(d_req_ready),  32'(e_dr));
            check("rst_if_rsp",   32'(if_rsp_valid), 32'(e_ifv));
            check("rst_d_rsp",    32'(d_rsp_valid),  32'(e_dv));
            check("rst_mem_wbe",  32'(mem_wbe),      32'(e_wbe));
            have_txn = 1'b0;
            last_d   = 1'b0;
            lat_idx  = '0;
        end else begin
            idle = !have_txn || (ncyc >= t_hs + 3);
            if (idle) begin
`ifdef MEM_ARB_RR_EN
                win_d = d_req_valid && (!if_req_valid || !last_d);
`else
                win_d = d_req_valid;
`endif
                win_if = if_req_valid && !win_d;
                e_ifr = win_if;
                e_dr  = win_d;
            end else if (ncyc == t_hs + 1) begin
                e_wbe = tx_wbe;
            end else if (ncyc == t_hs + 2) begin
                if (tx_is_d) begin
                    e_dv = 1'b1;
                    e_dd = (tx_wbe == 0) ? rmem[tx_idx] : 32'h0;
                end else begin
                    e_ifv = 1'b1;
                    e_ifd = rmem[tx_idx];
                end
            end

            check("if_req_ready", 32'(if_req_ready), 32'(e_ifr));
            check("d_req_ready",  32'(d_req_ready),  32'(e_dr));
            check("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
            check("d_rsp_valid",  32'(d_rsp_valid),  32'(e_dv));
            check("if_rsp_data",  if_rsp_data,       e_ifd);
            check("d_rsp_rdata",  d_rsp_rdata,       e_dd);
            check("mem_wbe",      32'(mem_wbe),      32'(e_wbe));
            check("mem_addr",     32'(mem_addr),     32'(lat_idx));
            if (!idle && ncyc == t_hs + 1 && tx_wbe != 0) begin
                check("mem_dw", mem_dw, tx_wd);
            end

            // store commits at the end of its access cycle
            if (!idle && ncyc == t_hs + 1) begin
                for (int b = 0; b < 4; b++) begin
                    if (tx_wbe[b]) rmem[tx_idx][8*b +: 8] = tx_wd[8*b +: 8];
                end
            end

            if (win_d || win_if) begin
                have_txn = 1'b1;
                t_hs     = ncyc;
                tx_is_d  = win_d;
                tx_idx   = win_d ? d_req_addr[15:2] : if_req_addr[15:2];
                tx_wbe   = win_d ? d_req_wbe : 4'h0;
                tx_wd    = d_req_wdata;
                lat_idx  = tx_idx;
                last_d   = win_d;
            end
        end
        ncyc++;
    end

    // ---------------- directed helpers ----------------
    task automatic access(input bit is_d, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [13:0] exp_idx,
                          input logic [31:0] exp_data, input string tag);
        int n;
        n = 0;
        if (is_d) begin
            d_req_valid = 1'b1; d_req_addr = a; d_req_wbe = be; d_req_wdata = wd;
        end else begin
            if_req_valid = 1'b1; if_req_addr = a;
        end
        @(negedge clk);
        check({tag, "_ready_T"}, 32'(is_d ? d_req_ready : if_req_ready), 32'd1);
        do begin @(posedge clk); n++; end while (!(is_d ? dut_hs_d : dut_hs_if) && n < 40);
        if (!(is_d ? dut_hs_d : dut_hs_if)) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no handshake within 40 cycles", tag);
        end
        #1;
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_mem_addr_T1"}, 32'(mem_addr), 32'(exp_idx));
        check({tag, "_mem_wbe_T1"},  32'(mem_wbe),  32'(is_d ? be : 4'h0));
        @(negedge clk);
        if (is_d) begin
            check({tag, "_rsp_valid_T2"}, 32'(d_rsp_valid), 32'd1);
            check({tag, "_rsp_data_T2"},  d_rsp_rdata,      exp_data);
            check({tag, "_other_quiet"},  32'(if_rsp_valid), 32'd0);
        end else begin
            check({tag, "_rsp_valid_T2"}, 32'(if_rsp_valid), 32'd1);
            check({tag, "_rsp_data_T2"},  if_rsp_data,       exp_data);
            check({tag, "_other_quiet"},  32'(d_rsp_valid),  32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_any_hs(output int who);
        int n;
        n = 0;
        do begin @(posedge clk); n++; end while (!(dut_hs_if || dut_hs_d) && n < 40);
        if (dut_hs_d)       who = 1;
        else if (dut_hs_if) who = 0;
        else begin
            who = 2;
            checks++; errors++;
            $display("FAIL hs_timeout: no handshake within 40 cycles");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int who;
        int hs_t[4];
        int cnt0;
        logic [31:0] v;

        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            bmem[i] = v; rmem[i] = v;
        end
        bmem[4]    = 32'hDEADBEEF; rmem[4]    = 32'hDEADBEEF;
        bmem[8]    = 32'h11223344; rmem[8]    = 32'h11223344;
        bmem[12]   = 32'h55AA55AA; rmem[12]   = 32'h55AA55AA;
        bmem[16]   = 32'hCAFEF00D; rmem[16]   = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_mem_addr", 32'(mem_addr),     32'd0);
        check("reset_mem_wbe",  32'(mem_wbe),      32'd0);
        check("reset_mem_dw",   mem_dw,            32'd0);
        check("reset_if_rsp",   32'(if_rsp_valid), 32'd0);
        check("reset_d_rsp",    32'(d_rsp_valid),  32'd0);
        check("reset_d_rdata",  d_rsp_rdata,       32'd0);
        @(posedge clk); #1;

        access(1'b1, 32'h0000_0010, 4'h0, 32'h0,          14'd4,    32'hDEADBEEF, "load10");
        access(1'b1, 32'h0000_0020, 4'h3, 32'h0000_ABCD, 14'd8,    32'h0,        "store20");
        access(1'b1, 32'h0000_0020, 4'h0, 32'h0,          14'd8,    32'h1122ABCD, "load20");
        access(1'b0, 32'h0000_0043, 4'h0, 32'h0,          14'h10,   32'hCAFEF00D, "fetch43");

        // both requesters continuously valid from reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0100;
        d_req_valid  = 1'b1; d_req_addr  = 32'h0000_0104; d_req_wbe = 4'h0;
        for (int k = 0; k < 6; k++) begin
            wait_any_hs(who);
`ifdef MEM_ARB_RR_EN
            check($sformatf("rr_grant_%0d", k), 32'(who), (k % 2 == 0) ? 32'd1 : 32'd0);
`else
            check($sformatf("fixed_grant_%0d", k), 32'(who), 32'd1);
`endif
        end
        #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // reset during the access cycle of a store
        d_req_valid = 1'b1; d_req_addr = 32'h0000_0030; d_req_wbe = 4'hF; d_req_wdata = 32'h1234_5678;
        wait_any_hs(who);
        #1;
        d_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_issue_mem_wbe", 32'(mem_wbe), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d_req_valid = 1'b1; d_req_wbe = 4'h0;
        @(negedge clk);
        check("rst_issue_no_d_rsp",  32'(d_rsp_valid),  32'd0);
        check("rst_issue_no_if_rsp", 32'(if_rsp_valid), 32'd0);
        check("rst_issue_idle",      32'(d_req_ready),  32'd1);
        check("rst_issue_word0c",    bmem[12],          32'h55AA55AA);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_issue_reload", d_rsp_rdata, 32'h55AA55AA);
        @(posedge clk); #1;

        // back-to-back fetches with valid held
        cnt0 = if_rsp_cnt;
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0044;
        for (int k = 0; k < 4; k++) begin
            wait_any_hs(who);
            hs_t[k] = ncyc;
        end
        #1 if_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 1; k < 4; k++) check($sformatf("b2b_gap_%0d", k), 32'(hs_t[k] - hs_t[k-1]), 32'd3);
        check("b2b_rsp_pulses", 32'(if_rsp_cnt - cnt0), 32'd4);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (dut_hs_if) if_req_valid = 1'b0;
            if (dut_hs_d)  d_req_valid  = 1'b0;
            rst = ($urandom_range(0, 149) == 0);
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = $urandom & 32'hF000_007F;
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1'b1;
                d_req_addr  = $urandom & 32'hF000_007F;
                d_req_wbe   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d_req_wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
